// File: rtl/clint_time_reader.sv
// clint_time_reader
// Hart-side initiator for the CLINT register port. Keeps a coherent 64-bit
// copy of mtime using a hi/lo/hi read loop, and performs tear-free 64-bit
// mtimecmp updates for one hart. It is the only master of the w_* port.
//
// Optional build macro: CLINT_TIME_INTERP_EN
//   defined   - a commit loads the sampled value plus the read-to-visible
//               lead, and w_time then advances by one every cycle so it
//               tracks mtime exactly between polls.
//   undefined - a commit loads the sampled value unchanged and w_time holds
//               until the next commit.

module clint_time_reader #(
    parameter int HART_ID       = 0,
    parameter int POLL_INTERVAL = 64
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] w_offset,
    output logic        w_we,
    output logic [31:0] w_wdata,
    input  logic [31:0] w_rdata,
    input  logic        cmp_req,
    input  logic [63:0] cmp_data,
    output logic        cmp_ack,
    output logic [63:0] w_time,
    output logic        w_time_vld
);

    // CLINT register map as seen from this hart
    localparam logic [15:0] MTIME_LO_OFS = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFS = 16'hBFFC;
    localparam logic [15:0] IDLE_OFS     = 16'h0000;
    localparam logic [15:0] CMP_LO_OFS   = 16'(32'h4000 + 8 * HART_ID);
    localparam logic [15:0] CMP_HI_OFS   = 16'(32'h4004 + 8 * HART_ID);

    // Last value of the free-running poll counter
    localparam logic [15:0] POLL_LAST    = 16'(POLL_INTERVAL - 1);

    // Written first so mtimecmp can never dip below old and new values
    localparam logic [31:0] CMP_LO_PARK  = 32'hFFFF_FFFF;

`ifdef CLINT_TIME_INTERP_EN
    // mtime advances this many times between the lo sample and visibility
    localparam logic [63:0] INTERP_LEAD  = 64'd3;
`endif

    typedef enum logic [3:0] {
        IDLE,
        RD_HI0,
        RD_LO,
        RD_HI1,
        CHK,
        WR_LO_MAX,
        WR_HI,
        WR_LO,
        ACK
    } state_t;

    state_t      state;
    logic [15:0] poll_cnt;
    logic        poll_pend;
    logic [31:0] hi0;
    logic [31:0] lo;

    logic        hi_match;
    logic        commit;
    logic        start_poll;
    logic        enter_rd_hi0;

    // In CHK the second high-word read is arriving on w_rdata this cycle
    assign hi_match     = (w_rdata == hi0);
    assign commit       = (state == CHK) && hi_match;
    assign start_poll   = (state == IDLE) && !cmp_req && poll_pend;
    assign enter_rd_hi0 = start_poll || ((state == CHK) && !hi_match);

    // Free-running poll interval counter, wraps at POLL_INTERVAL-1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            poll_cnt <= 16'd0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= 16'd0;
        end else begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end

    // Poll request flag: set by the counter, consumed when a read pass begins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            poll_pend <= 1'b1;
        end else if (poll_cnt == POLL_LAST) begin
            poll_pend <= 1'b1;
        end else if (enter_rd_hi0) begin
            poll_pend <= 1'b0;
        end
    end

    // Bus sequencer: outputs are registered together with the state they belong to
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            w_offset <= IDLE_OFS;
            w_we     <= 1'b0;
            w_wdata  <= 32'd0;
            cmp_ack  <= 1'b0;
            hi0      <= 32'd0;
            lo       <= 32'd0;
        end else begin
            w_offset <= IDLE_OFS;
            w_we     <= 1'b0;
            w_wdata  <= 32'd0;
            cmp_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmp_req) begin
                        state    <= WR_LO_MAX;
                        w_offset <= CMP_LO_OFS;
                        w_wdata  <= CMP_LO_PARK;
                        w_we     <= 1'b1;
                    end else if (poll_pend) begin
                        state    <= RD_HI0;
                        w_offset <= MTIME_HI_OFS;
                    end
                end
                RD_HI0: begin
                    state    <= RD_LO;
                    w_offset <= MTIME_LO_OFS;
                end
                RD_LO: begin
                    state    <= RD_HI1;
                    w_offset <= MTIME_HI_OFS;
                    hi0      <= w_rdata;
                end
                RD_HI1: begin
                    state <= CHK;
                    lo    <= w_rdata;
                end
                CHK: begin
                    if (hi_match) begin
                        state <= IDLE;
                    end else begin
                        state    <= RD_HI0;
                        w_offset <= MTIME_HI_OFS;
                    end
                end
                WR_LO_MAX: begin
                    state    <= WR_HI;
                    w_offset <= CMP_HI_OFS;
                    w_wdata  <= cmp_data[63:32];
                    w_we     <= 1'b1;
                end
                WR_HI: begin
                    state    <= WR_LO;
                    w_offset <= CMP_LO_OFS;
                    w_wdata  <= cmp_data[31:0];
                    w_we     <= 1'b1;
                end
                WR_LO: begin
                    state   <= ACK;
                    cmp_ack <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Time register: loads on a consistent read, optionally free-runs in between
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_time     <= 64'd0;
            w_time_vld <= 1'b0;
        end else if (commit) begin
`ifdef CLINT_TIME_INTERP_EN
            w_time     <= {hi0, lo} + INTERP_LEAD;
`else
            w_time     <= {hi0, lo};
`endif
            w_time_vld <= 1'b1;
        end
`ifdef CLINT_TIME_INTERP_EN
        else if (w_time_vld) begin
            w_time <= w_time + 64'd1;
        end
`endif
    end

endmodule

// File: tb/tb_clint_time_reader.sv
// tb_clint_time_reader
// Directed and randomized bench for clint_time_reader with a small CLINT
// model (mtime, two mtimecmp registers, registered read port). Expected
// values come from the cycle-level rules of the block: reads start every
// POLL_INTERVAL cycles, a commit carries the mtime seen three cycles earlier
// (or current mtime with CLINT_TIME_INTERP_EN), writes take three beats.

module tb_clint_time_reader;

    localparam int HART = 1;
    localparam int PI   = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] w_offset;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        cmp_req = 1'b0;
    logic [63:0] cmp_data = 64'd0;
    logic        cmp_ack;
    logic [63:0] w_time;
    logic        w_time_vld;

    logic [63:0] mtime;
    logic [63:0] mtime_preload = 64'd0;
    logic        mtime_run;
    logic [63:0] mtimecmp [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;

    clint_time_reader #(
        .HART_ID       (HART),
        .POLL_INTERVAL (PI)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .w_offset   (w_offset),
        .w_we       (w_we),
        .w_wdata    (w_wdata),
        .w_rdata    (w_rdata),
        .cmp_req    (cmp_req),
        .cmp_data   (cmp_data),
        .cmp_ack    (cmp_ack),
        .w_time     (w_time),
        .w_time_vld (w_time_vld)
    );

    // CLINT model: mtime starts counting one cycle after reset release,
    // register reads return the value for the offset driven one cycle earlier
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mtime       <= mtime_preload;
            mtime_run   <= 1'b0;
            w_rdata     <= 32'd0;
            mtimecmp[0] <= 64'd0;
            mtimecmp[1] <= 64'd0;
        end else begin
            mtime_run <= 1'b1;
            if (mtime_run) mtime <= mtime + 64'd1;
            if (w_we) begin
                case (w_offset)
                    16'h4000: mtimecmp[0][31:0]  <= w_wdata;
                    16'h4004: mtimecmp[0][63:32] <= w_wdata;
                    16'h4008: mtimecmp[1][31:0]  <= w_wdata;
                    16'h400C: mtimecmp[1][63:32] <= w_wdata;
                    default: ;
                endcase
            end
            case (w_offset)
                16'hBFF8: w_rdata <= mtime[31:0];
                16'hBFFC: w_rdata <= mtime[63:32];
                16'h4000: w_rdata <= mtimecmp[0][31:0];
                16'h4004: w_rdata <= mtimecmp[0][63:32];
                16'h4008: w_rdata <= mtimecmp[1][31:0];
                16'h400C: w_rdata <= mtimecmp[1][63:32];
                default:  w_rdata <= 32'd0;
            endcase
        end
    end

    // mtime value during cycle k after reset release with preload p
    function automatic logic [63:0] mtimeAt(input logic [63:0] p, input int k);
        if (k < 1) return p;
        return p + 64'(k - 1);
    endfunction

    // Value carried by a commit that becomes visible in cycle v
    function automatic logic [63:0] commitValue(input logic [63:0] p, input int v);
`ifdef CLINT_TIME_INTERP_EN
        return mtimeAt(p, v);
`else
        return mtimeAt(p, v - 3);
`endif
    endfunction

    // w_time in cycle c of an undisturbed polling run (no carry, no writes)
    function automatic logic [63:0] expectedTime(input logic [63:0] p, input int c);
        if (c < 5) return 64'd0;
`ifdef CLINT_TIME_INTERP_EN
        return mtimeAt(p, c);
`else
        return commitValue(p, PI * ((c - 5) / PI) + 5);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWriteBeat(input string tag, input logic [15:0] ofs,
                                  input logic [31:0] data);
        checkOutput({tag, "_we"},   64'(w_we),     64'd1);
        checkOutput({tag, "_ofs"},  64'(w_offset), 64'(ofs));
        checkOutput({tag, "_data"}, 64'(w_wdata),  64'(data));
        checkOutput({tag, "_ack"},  64'(cmp_ack),  64'd0);
    endtask

    task automatic applyStimulus(input logic req, input logic [63:0] data);
        cmp_data = data;
        cmp_req  = req;
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic applyReset(input logic [63:0] p);
        @(negedge CLK);
        mtime_preload = p;
        RST           = 1'b1;
        cmp_req       = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] p;
        logic [63:0] wdat;
        int          r;

        $display("[TB] start, HART_ID=%0d POLL_INTERVAL=%0d", HART, PI);

        // Reset values with mtime = 0
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_ofs",   64'(w_offset),   64'd0);
        checkOutput("rst_we",    64'(w_we),       64'd0);
        checkOutput("rst_wdata", 64'(w_wdata),    64'd0);
        checkOutput("rst_ack",   64'(cmp_ack),    64'd0);
        checkOutput("rst_time",  w_time,          64'd0);
        checkOutput("rst_vld",   64'(w_time_vld), 64'd0);
        RST = 1'b0;
        cyc = 0;

        // First poll right after reset release
        stepCycle();
        checkOutput("c1_ofs", 64'(w_offset), 64'hBFFC);
        checkOutput("c1_we",  64'(w_we),     64'd0);
        while (cyc < 4) stepCycle();
        checkOutput("c4_vld", 64'(w_time_vld), 64'd0);
        stepCycle();
        checkOutput("c5_vld",  64'(w_time_vld), 64'd1);
        checkOutput("c5_time", w_time, commitValue(64'd0, 5));

        // Periodic polling schedule and held/tracking time
        for (int c = 6; c <= 40; c++) begin
            stepCycle();
            r = (cyc - 1) % PI;
            if (r <= 2)
                checkOutput($sformatf("poll_ofs_c%0d", cyc), 64'(w_offset),
                            (r == 1) ? 64'hBFF8 : 64'hBFFC);
            else if (r >= 4)
                checkOutput($sformatf("idle_ofs_c%0d", cyc), 64'(w_offset), 64'd0);
            checkOutput($sformatf("poll_time_c%0d", cyc), w_time, expectedTime(64'd0, cyc));
        end

        // Preloaded mtime, first commit
        p = 64'h0000_0001_0000_0005;
        applyReset(p);
        while (cyc < 4) stepCycle();
        checkOutput("pre_c4_time", w_time, 64'd0);
        stepCycle();
        checkOutput("pre_c5_time", w_time, commitValue(p, 5));

        // High word rolls over between the two high reads: one retry
        p = 64'h0000_0000_FFFF_FFFE;
        applyReset(p);
        for (int c = 1; c <= 8; c++) begin
            stepCycle();
            checkOutput($sformatf("carry_hold_c%0d", cyc), w_time, 64'd0);
            if (cyc == 5)
                checkOutput("carry_retry_ofs", 64'(w_offset), 64'hBFFC);
        end
        checkOutput("carry_c8_vld", 64'(w_time_vld), 64'd0);
        stepCycle();
        checkOutput("carry_c9_vld",  64'(w_time_vld), 64'd1);
        checkOutput("carry_c9_time", w_time, commitValue(p, 9));

        // mtimecmp write for hart 1, request seen in IDLE at cycle 5
        applyReset(64'd0);
        while (cyc < 5) stepCycle();
        applyStimulus(1'b1, 64'h0000_0002_0000_0010);
        stepCycle();
        checkWriteBeat("wr_beat0", 16'h4008, 32'hFFFF_FFFF);
        stepCycle();
        checkWriteBeat("wr_beat1", 16'h400C, 32'h0000_0002);
        stepCycle();
        checkWriteBeat("wr_beat2", 16'h4008, 32'h0000_0010);
        stepCycle();
        checkOutput("wr_ack",    64'(cmp_ack), 64'd1);
        checkOutput("wr_ack_we", 64'(w_we),    64'd0);
        applyStimulus(1'b0, 64'h0000_0002_0000_0010);
        stepCycle();
        checkOutput("wr_ack_gone", 64'(cmp_ack),  64'd0);
        checkOutput("wr_idle_ofs", 64'(w_offset), 64'd0);
        checkOutput("wr_cmp1",     mtimecmp[1],   64'h0000_0002_0000_0010);

        // Write request arriving together with a pending poll wins; poll follows
        while (cyc < PI) stepCycle();
        wdat = {$urandom, $urandom};
        applyStimulus(1'b1, wdat);
        stepCycle();
        checkWriteBeat("col_beat0", 16'h4008, 32'hFFFF_FFFF);
        stepCycle();
        checkWriteBeat("col_beat1", 16'h400C, wdat[63:32]);
        stepCycle();
        checkWriteBeat("col_beat2", 16'h4008, wdat[31:0]);
        stepCycle();
        checkOutput("col_ack", 64'(cmp_ack), 64'd1);
        applyStimulus(1'b0, wdat);
        stepCycle();
        checkOutput("col_idle_ofs", 64'(w_offset), 64'd0);
        checkOutput("col_idle_we",  64'(w_we),     64'd0);
        checkOutput("col_cmp1",     mtimecmp[1],   wdat);
        stepCycle();
        checkOutput("col_rd_hi0", 64'(w_offset), 64'hBFFC);
        while (cyc < PI + 10) stepCycle();
        checkOutput("col_commit", w_time, commitValue(64'd0, PI + 10));

        // Random preloads, w_time checked every cycle against the schedule
        for (int run = 0; run < 4; run++) begin
            p = {$urandom, 32'($urandom_range(32'hFFF0_0000, 0))};
            applyReset(p);
            for (int c = 1; c <= 250; c++) begin
                stepCycle();
                checkOutput($sformatf("rand%0d_time_c%0d", run, cyc), w_time,
                            expectedTime(p, cyc));
                checkOutput($sformatf("rand%0d_vld_c%0d", run, cyc), 64'(w_time_vld),
                            (cyc >= 5) ? 64'd1 : 64'd0);
            end
        end

        // Asynchronous reset in the middle of an mtimecmp update
        applyReset(64'd0);
        while (cyc < 5) stepCycle();
        applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0);
        stepCycle();
        stepCycle();
        checkOutput("arst_pre_we",  64'(w_we),     64'd1);
        checkOutput("arst_pre_ofs", 64'(w_offset), 64'h400C);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("arst_we",    64'(w_we),       64'd0);
        checkOutput("arst_ofs",   64'(w_offset),   64'd0);
        checkOutput("arst_wdata", 64'(w_wdata),    64'd0);
        checkOutput("arst_ack",   64'(cmp_ack),    64'd0);
        checkOutput("arst_time",  w_time,          64'd0);
        checkOutput("arst_vld",   64'(w_time_vld), 64'd0);
        applyStimulus(1'b0, 64'h1234_5678_9ABC_DEF0);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            checkOutput($sformatf("arst_noack_c%0d", cyc), 64'(cmp_ack), 64'd0);
            if (cyc == 1)
                checkOutput("arst_poll_ofs", 64'(w_offset), 64'hBFFC);
            if (cyc == 5)
                checkOutput("arst_poll_vld", 64'(w_time_vld), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
